// File: rtl/instr_mem_loader_if.sv
// Byte-stream input and instruction-memory write channel of the program loader.
// The master modport is the loader side; the slave modport is the environment side.
interface instr_mem_loader_if #(
  parameter int unsigned ADDR_W = 15
);
  logic              byte_vld;
  logic [7:0]        byte_data;
  logic              byte_rdy;
  logic              wr_vld;
  logic [ADDR_W-1:0] wr_addr;
  logic [63:0]       wr_data;
  logic              wr_rdy;

  modport master (
    input  byte_vld, byte_data, wr_rdy,
    output byte_rdy, wr_vld, wr_addr, wr_data
  );

  modport slave (
    output byte_vld, byte_data, wr_rdy,
    input  byte_rdy, wr_vld, wr_addr, wr_data
  );
endinterface

// File: rtl/instr_mem_loader.sv
// Packs an upstream byte stream little-endian into 64-bit words and writes them
// to consecutive instruction-memory addresses starting at 0.
module instr_mem_loader #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned CNT_W  = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic [CNT_W-1:0]   i_word_cnt,
  instr_mem_loader_if.master bus,
  output logic               o_instr_mem_wr_finish,
  output logic               o_busy,
  output logic               o_err
);

  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

  state_t            state;
  logic [CNT_W-1:0]  words_left;
  logic [2:0]        byte_idx;
  logic [ADDR_W-1:0] addr;
  logic [63:0]       data;
  logic              byte_rdy;
  logic              wr_vld;
  logic              finish;
  logic              busy;
  logic              err;

  assign bus.byte_rdy          = byte_rdy;
  assign bus.wr_vld            = wr_vld;
  assign bus.wr_addr           = addr;
  assign bus.wr_data           = data;
  assign o_instr_mem_wr_finish = finish;
  assign o_busy                = busy;
  assign o_err                 = err;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      words_left <= '0;
      byte_idx   <= '0;
      addr       <= '0;
      data       <= '0;
      byte_rdy   <= 1'b0;
      wr_vld     <= 1'b0;
      finish     <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (i_start) begin
            err      <= 1'b0;
            addr     <= '0;
            data     <= '0;
            byte_idx <= '0;
            if (i_word_cnt != '0) begin
              state      <= FILL;
              words_left <= i_word_cnt;
              byte_rdy   <= 1'b1;
              busy       <= 1'b1;
              finish     <= 1'b0;
            end else begin
              state  <= DONE;
              finish <= 1'b1;
            end
          end
        end

        FILL: begin
          if (i_start) err <= 1'b1;
          if (bus.byte_vld && byte_rdy) begin
            data[{byte_idx, 3'b000} +: 8] <= bus.byte_data;
            byte_idx <= byte_idx + 3'd1;
            if (byte_idx == 3'd7) begin
              state    <= WRITE;
              byte_rdy <= 1'b0;
              wr_vld   <= 1'b1;
            end
          end
        end

        WRITE: begin
          if (i_start) err <= 1'b1;
          // vld/addr/data are only touched on the handshake, so they hold through stalls
          if (bus.wr_rdy) begin
            wr_vld     <= 1'b0;
            addr       <= addr + ADDR_W'(1);
            words_left <= words_left - CNT_W'(1);
            if (words_left == CNT_W'(1)) begin
              state  <= DONE;
              busy   <= 1'b0;
              finish <= 1'b1;
            end else begin
              state    <= FILL;
              byte_rdy <= 1'b1;
              byte_idx <= '0;
              data     <= '0;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: random byte/ready gaps, a packing
// reference model feeding an expected-write queue, and an independent monitor.
module tb_instr_mem_loader;
  localparam int unsigned ADDR_W = 15;
  localparam int unsigned CNT_W  = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] word_cnt;
  logic             finish;
  logic             busy;
  logic             err;

  instr_mem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  instr_mem_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .i_clk                 (clk),
    .i_rst_n               (rst_n),
    .i_start               (start),
    .i_word_cnt            (word_cnt),
    .bus                   (bus),
    .o_instr_mem_wr_finish (finish),
    .o_busy                (busy),
    .o_err                 (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [63:0]       data;
  } wr_t;

  wr_t         exp_q[$];
  logic [7:0]  feed_q[$];
  int unsigned vld_pct = 100;
  int unsigned rdy_pct = 100;
  int          stall = 0;
  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          writes_seen = 0;
  int          vld_cycles = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  // Reference model: words are consecutive groups of 8 bytes, first byte in the LSBs,
  // written to addresses 0,1,2,... of a fresh load (mod 2^ADDR_W).
  task automatic gen_load(input int unsigned words, input int unsigned extra, input bit incr);
    logic [63:0] w;
    logic [7:0]  b;
    int unsigned n;
    n = 0;
    for (int unsigned wi = 0; wi < words; wi++) begin
      w = '0;
      for (int unsigned k = 0; k < 8; k++) begin
        b = incr ? 8'(n) : 8'($urandom);
        n++;
        w = w | (64'(b) << (8 * k));
        feed_q.push_back(b);
      end
      exp_q.push_back('{addr: ADDR_W'(wi), data: w});
    end
    for (int unsigned e = 0; e < extra; e++) begin
      feed_q.push_back(incr ? 8'(n) : 8'($urandom));
      n++;
    end
  endtask

  task automatic do_start(input logic [CNT_W-1:0] n);
    @(posedge clk); #1;
    start    = 1'b1;
    word_cnt = n;
    @(posedge clk); #1;
    start    = 1'b0;
    word_cnt = CNT_W'($urandom);
  endtask

  task automatic wait_finish(input int limit, output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!finish && cycles < limit);
    if (!finish) check("finish_timeout", finish, 1'b1);
  endtask

  // Byte source
  initial begin
    bus.byte_vld  = 1'b0;
    bus.byte_data = '0;
    forever begin
      @(posedge clk); #1;
      if (feed_q.size() != 0 && $urandom_range(99) < vld_pct) begin
        bus.byte_vld  = 1'b1;
        bus.byte_data = feed_q[0];
      end else begin
        bus.byte_vld  = 1'b0;
        bus.byte_data = 8'($urandom);
      end
      @(negedge clk);
      if (bus.byte_vld && bus.byte_rdy && feed_q.size() != 0) feed_q.delete(0);
    end
  end

  // Memory-side ready
  initial begin
    bus.wr_rdy = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (stall > 0 && bus.wr_vld) begin
        bus.wr_rdy = 1'b0;
        stall--;
      end else begin
        bus.wr_rdy = ($urandom_range(99) < rdy_pct);
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    logic              prev_vld;
    logic              prev_rdy;
    logic [ADDR_W-1:0] prev_addr;
    logic [63:0]       prev_data;
    wr_t               e;
    prev_vld = 1'b0;
    prev_rdy = 1'b0;
    prev_addr = '0;
    prev_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_vld = 1'b0;
      end else begin
        if (prev_vld && !prev_rdy) begin
          check("wr_vld_held", bus.wr_vld, 1'b1);
          check("wr_addr_held", bus.wr_addr, prev_addr);
          check("wr_data_held", bus.wr_data, prev_data);
        end
        if (bus.wr_vld) vld_cycles++;
        if (bus.wr_vld && bus.wr_rdy) begin
          writes_seen++;
          if (exp_q.size() == 0) begin
            total_cnt++;
            $display("FAIL unexpected_write: got addr %0h data %0h, required no write",
                     bus.wr_addr, bus.wr_data);
          end else begin
            e = exp_q.pop_front();
            check("wr_addr", bus.wr_addr, e.addr);
            check("wr_data", bus.wr_data, e.data);
          end
        end
        prev_vld  = bus.wr_vld;
        prev_rdy  = bus.wr_rdy;
        prev_addr = bus.wr_addr;
        prev_data = bus.wr_data;
      end
    end
  end

  initial begin
    int cyc;
    int base;
    rst_n    = 1'b0;
    start    = 1'b0;
    word_cnt = '0;
    repeat (3) @(negedge clk);
    check("rst_byte_rdy", bus.byte_rdy, 1'b0);
    check("rst_wr_vld", bus.wr_vld, 1'b0);
    check("rst_finish", finish, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_addr", bus.wr_addr, '0);
    check("rst_data", bus.wr_data, '0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Zero-length load from IDLE
    vld_cycles = 0;
    do_start('0);
    @(negedge clk);
    check("zero_finish", finish, 1'b1);
    check("zero_busy", busy, 1'b0);
    repeat (4) @(negedge clk);
    check("zero_no_vld", vld_cycles, 0);

    // Two words of 0x00..0x0F with everything ready: finish 19 cycles after start
    vld_pct = 100; rdy_pct = 100;
    gen_load(2, 0, 1'b1);
    do_start(2);
    @(negedge clk);
    cyc = 1;
    check("fill_busy", busy, 1'b1);
    check("fill_byte_rdy", bus.byte_rdy, 1'b1);
    check("fill_finish_low", finish, 1'b0);
    while (!finish && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("finish_cycle", cyc, 19);
    check("two_word_drained", exp_q.size(), 0);

    // One word with ready held low for five WRITE cycles
    vld_cycles = 0;
    base = writes_seen;
    gen_load(1, 0, 1'b0);
    stall = 5;
    do_start(1);
    wait_finish(100, cyc);
    check("stall_vld_cycles", vld_cycles, 6);
    check("stall_one_write", writes_seen - base, 1);
    check("stall_done_busy", busy, 1'b0);

    // Start pulsed mid-FILL is ignored but flagged
    gen_load(2, 0, 1'b0);
    do_start(2);
    repeat (3) @(negedge clk);
    check("err_before", err, 1'b0);
    do_start(7);
    @(negedge clk);
    check("err_set", err, 1'b1);
    wait_finish(200, cyc);
    check("err_load_drained", exp_q.size(), 0);
    check("err_sticky", err, 1'b1);
    do_start('0);
    @(negedge clk);
    check("err_cleared", err, 1'b0);
    check("err_restart_finish", finish, 1'b1);

    // Reset in the middle of the fourth word
    gen_load(3, 5, 1'b0);
    do_start(5);
    cyc = 0;
    while (feed_q.size() != 0 && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    check("abort_feed_timeout", feed_q.size(), 0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_wr_vld", bus.wr_vld, 1'b0);
    check("abort_byte_rdy", bus.byte_rdy, 1'b0);
    check("abort_addr", bus.wr_addr, '0);
    check("abort_data", bus.wr_data, '0);
    check("abort_written", exp_q.size(), 0);
    feed_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    vld_cycles = 0;
    repeat (5) @(negedge clk);
    check("abort_no_write", vld_cycles, 0);
    gen_load(1, 0, 1'b0);
    do_start(1);
    wait_finish(100, cyc);
    check("abort_reload_drained", exp_q.size(), 0);

    // 300 words with random byte and ready gaps
    vld_pct = 60; rdy_pct = 50;
    base = writes_seen;
    gen_load(300, 0, 1'b0);
    do_start(300);
    wait_finish(30000, cyc);
    @(negedge clk);
    check("bulk_writes", writes_seen - base, 300);
    check("bulk_drained", exp_q.size(), 0);
    check("bulk_err", err, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
